mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter addr_width_p, default 4, giving the register address width; it SHALL match the register file's address width.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET_N, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start_i, input, 1, a request to begin an operation.
REQ-005 SHALL have port op_i, input, 2: 00 MUL, 01 DIVU, 10 REMU, 11 reserved.
REQ-006 SHALL have ports a_i and b_i, input, 8 each, unsigned operands (rs value, rt value).
REQ-007 SHALL have port rd_addr_i, input, addr_width_p, the destination register.
REQ-008 SHALL have port busy_o, output, 1; high means the unit is occupied and stalls the CPU.
REQ-009 SHALL have port done_o, output, 1, a completion pulse.
REQ-010 SHALL have ports wen_o and oen_o, output, 1 each, driving the register file's write enable and overflow-update enable.
REQ-011 SHALL have port rd_addr_o, output, addr_width_p, the write address.
REQ-012 SHALL have port write_data_o, output, 8, the result.
REQ-013 SHALL have port overflow_o, output, 1, the overflow / divide-by-zero flag for the register file.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and WB, with transitions IDLE->RUN, RUN->WB and WB->IDLE.
REQ-015 SHALL, in IDLE with start_i=1 and op_i!=11 at edge E0, capture a_i, b_i, op_i and rd_addr_i, clear a 3-bit iteration counter, and enter RUN.
REQ-016 SHALL ignore start_i when op_i=11 (stay IDLE) and in RUN or WB; captured operands SHALL stay unchanged while busy.
REQ-017 SHALL, in RUN, perform exactly one iteration per cycle for 8 cycles (E1..E8); the counter SHALL wrap 7->0 at E8, entering WB.
REQ-018 SHALL implement MUL as shift-add of the captured operands into a 16-bit product; the result is product[7:0] and the overflow flag is the OR of product[15:8].
REQ-019 SHALL implement DIVU and REMU as restoring division, one quotient bit per iteration, MSB first; the result is the quotient or the remainder respectively, and the overflow flag is 0.
REQ-020 SHALL, when b=0 in DIVU or REMU, set the overflow flag to 1 and produce a quotient of 0xFF and a remainder equal to a; the iteration count SHALL be unchanged (still 8).
REQ-021 SHALL, on the cycle after E8 (the WB state), drive done_o=1 and oen_o=1 and drive wen_o=1, for exactly one cycle; the WB->IDLE transition is at E9.
REQ-022 SHALL drive wen_o=0 in WB when the captured rd is 6 or 7 (constant registers), while done_o and oen_o still pulse.
REQ-023 SHALL load write_data_o, rd_addr_o and overflow_o from registers on entry to WB and hold them until the next WB.
REQ-024 SHALL hold wen_o, oen_o and done_o at 0 outside WB.
REQ-025 SHALL assert busy_o combinationally from state (RUN or WB), i.e. from after E0 through E9; total latency from the start edge to the write edge is 9 cycles.
REQ-026 SHALL drive all outputs from registers or from state decode only, with no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, while RESET_N=0, immediately force state=IDLE and counter=0, clear all captured operands, and set busy_o, done_o, wen_o, oen_o, overflow_o, write_data_o and rd_addr_o to 0.
REQ-028 SHALL, on reset during RUN or WB, abort the operation with no register write; the first start after RESET_N rises SHALL behave per REQ-015.

Verification
REQ-029 SHALL cover: MUL a=12, b=10, rd=3 -> busy 9 cycles; at WB write_data_o=0x78, overflow_o=0, wen_o=1, rd_addr_o=3 for one cycle.
REQ-030 SHALL cover: MUL a=0x20, b=0x10 -> write_data_o=0x00, overflow_o=1, oen_o=1; and MUL 0xFF*0xFF -> 0x01, overflow_o=1.
REQ-031 SHALL cover: DIVU 200/7 -> 0x1C, overflow_o=0; REMU 200/7 -> 0x04; DIVU 5/0 -> 0xFF, overflow_o=1; REMU 5/0 -> 0x05, overflow_o=1.
REQ-032 SHALL cover: start DIVU 100/3 rd=4, then start MUL 2*2 rd=5 during RUN -> the second start is ignored; one WB with 0x21 to rd 4; afterwards the unit accepts a new start.
REQ-033 SHALL cover: RESET_N low during RUN iteration 4 -> outputs 0 while low, no wen_o pulse; after release, MUL 3*3 -> 0x09 after 9 cycles.
REQ-034 SHALL cover: MUL 2*3 with rd=7 -> done_o=1, oen_o=1, wen_o=0; and op_i=11 with start_i=1 -> busy_o stays 0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Sequential 8-bit multiply / unsigned divide unit. It runs for eight cycles, then
// spends one write-back cycle driving the register-file write and overflow enables.
module mul_div_unit #(
  parameter int addr_width_p = 4
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    start_i,
  input  logic [1:0]              op_i,
  input  logic [7:0]              a_i,
  input  logic [7:0]              b_i,
  input  logic [addr_width_p-1:0] rd_addr_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    wen_o,
  output logic                    oen_o,
  output logic [addr_width_p-1:0] rd_addr_o,
  output logic [7:0]              write_data_o,
  output logic                    overflow_o
);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_e;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  state_e                  state_q;
  logic [7:0]              a_q, b_q;
  logic [1:0]              op_q;
  logic [addr_width_p-1:0] rd_q;
  logic [2:0]              cnt_q;
  logic [15:0]             prod_q, prod_d;
  logic [7:0]              rem_q, rem_d, quot_q, quot_d;
  logic [8:0]              trial, diff;
  logic                    fits;
  logic [7:0]              res_d;
  logic                    ovf_d;
  logic                    done_q, wen_q, oen_q, ovf_q;
  logic [7:0]              wdata_q;
  logic [addr_width_p-1:0] rd_out_q;

  // One shift-add step (multiplier bit cnt_q) and one restoring-division step
  // (dividend bit 7-cnt_q) are evaluated every cycle; op_q picks the result.
  always_comb begin
    prod_d = prod_q + (b_q[cnt_q] ? ({8'b0, a_q} << cnt_q) : 16'd0);
    trial  = {rem_q, a_q[3'd7 - cnt_q]};
    diff   = trial - {1'b0, b_q};
    fits   = (trial >= {1'b0, b_q});
    rem_d  = fits ? diff[7:0] : trial[7:0];
    quot_d = {quot_q[6:0], fits};
    res_d  = 8'h00;
    ovf_d  = 1'b0;
    case (op_q)
      OP_MUL: begin
        res_d = prod_d[7:0];
        ovf_d = |prod_d[15:8];
      end
      // Divide-by-zero falls out of the datapath: every trial fits, giving
      // quotient 0xFF and a remainder equal to the dividend.
      OP_DIVU: begin
        res_d = quot_d;
        ovf_d = (b_q == 8'h00);
      end
      OP_REMU: begin
        res_d = rem_d;
        ovf_d = (b_q == 8'h00);
      end
      default: begin
        res_d = 8'h00;
        ovf_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      done_q   <= 1'b0;
      wen_q    <= 1'b0;
      oen_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wdata_q  <= '0;
      rd_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && op_i != 2'b11) begin
            a_q     <= a_i;
            b_q     <= b_i;
            op_q    <= op_i;
            rd_q    <= rd_addr_i;
            cnt_q   <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          prod_q <= prod_d;
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q  <= WB;
            wdata_q  <= res_d;
            ovf_q    <= ovf_d;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            oen_q    <= 1'b1;
            // Registers 6 and 7 are hard-wired constants and must not be written.
            wen_q    <= (rd_q != 6) && (rd_q != 7);
          end
        end
        WB: begin
          done_q  <= 1'b0;
          wen_q   <= 1'b0;
          oen_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = (state_q == RUN) || (state_q == WB);
  assign done_o       = done_q;
  assign wen_o        = wen_q;
  assign oen_o        = oen_q;
  assign overflow_o   = ovf_q;
  assign write_data_o = wdata_q;
  assign rd_addr_o    = rd_out_q;

endmodule
